time_display: RTL

- Display-side consumer of the stopwatch's packed time word {minutes[5:0], seconds[5:0]}.
- On request, converts both 6-bit fields to two BCD digits each, using a sequential shift-add-3 (double-dabble) conversion.
- Drives a 4-digit multiplexed 7-segment display from the converted value.
- Sits between the stopwatch counter and the board's seven-segment pins.

---
 rtl/time_display_pkg.sv | 29 ++
 rtl/time_display_seg7_decoder.sv | 28 ++
 rtl/time_display.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/time_display_pkg.sv
// Shared types and constants for the time_display block: FSM state
// encoding, scan digit index, segment patterns and conversion length.
package time_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    typedef logic [1:0] digit_idx_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // One shift per binary bit of a 6-bit time field
    localparam int SHIFT_CYCLES = 6;

endpackage

// File: rtl/time_display_seg7_decoder.sv
// seg7_decoder: combinational BCD digit to 7-segment pattern.
// Codes 10..15 are not valid BCD and produce a blank digit.
module seg7_decoder
    import time_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one BCD digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display.sv
// time_display: converts a packed {minutes, seconds} word to four BCD
// digits with a sequential double-dabble and scans them onto a 4-digit
// multiplexed 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the minutes-tens
// digit when it is zero (scan timing is unchanged).
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int FIELD_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*FIELD_W-1:0]   time_in,
    input  logic                   update,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            bcd_out,
    output logic [3:0]             digit_sel,
    output logic [6:0]             seg,
    output logic                   dp
);

    // Shift register per field: {tens[3:0], ones[3:0], binary[FIELD_W-1:0]}
    localparam int DD_W = FIELD_W + 8;
    localparam logic [2:0] LAST_SHIFT = 3'(SHIFT_CYCLES - 1);

    state_t            state;
    logic [2:0]        shift_cnt;
    logic [DD_W-1:0]   sr_min;
    logic [DD_W-1:0]   sr_sec;
    logic [DD_W-1:0]   min_nx;
    logic [DD_W-1:0]   sec_nx;
    logic              pending;
    logic [15:0]       prescaler;
    digit_idx_t        digit_idx;
    logic [3:0]        nibble;
    logic [6:0]        seg_dec;

    // One double-dabble step: add 3 to any nibble >= 5, then shift left,
    // pulling the next binary MSB into the ones LSB.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] a;
        a = v;
        if (a[DD_W-1 -: 4] >= 4'd5)
            a[DD_W-1 -: 4] = a[DD_W-1 -: 4] + 4'd3;
        if (a[DD_W-5 -: 4] >= 4'd5)
            a[DD_W-5 -: 4] = a[DD_W-5 -: 4] + 4'd3;
        return {a[DD_W-2:0], 1'b0};
    endfunction

    assign min_nx = dd_step(sr_min);
    assign sec_nx = dd_step(sr_sec);

    // Conversion FSM: latch request, shift six times, publish result.
    // A request arriving while busy or in LOAD is held in pending and
    // started straight out of LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_cnt <= '0;
            sr_min    <= '0;
            sr_sec    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            pending   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update || pending) begin
                        sr_min    <= {8'd0, time_in[2*FIELD_W-1:FIELD_W]};
                        sr_sec    <= {8'd0, time_in[FIELD_W-1:0]};
                        shift_cnt <= '0;
                        pending   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (update)
                        pending <= 1'b1;
                    sr_min    <= min_nx;
                    sr_sec    <= sec_nx;
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == LAST_SHIFT) begin
                        // Final shift: publish directly so bcd_out and done
                        // are visible during the LOAD cycle.
                        bcd_out <= {min_nx[DD_W-1 -: 8], sec_nx[DD_W-1 -: 8]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (pending || update) begin
                        sr_min    <= {8'd0, time_in[2*FIELD_W-1:FIELD_W]};
                        sr_sec    <= {8'd0, time_in[FIELD_W-1:0]};
                        shift_cnt <= '0;
                        pending   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan prescaler; digit index advances on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (prescaler == 16'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Select the active digit's nibble from the published value
    always_comb begin
        nibble = bcd_out[3:0];
        case (digit_idx)
            2'd0: nibble = bcd_out[3:0];
            2'd1: nibble = bcd_out[7:4];
            2'd2: nibble = bcd_out[11:8];
            2'd3: nibble = bcd_out[15:12];
            default: nibble = bcd_out[3:0];
        endcase
    end

    seg7_decoder u_dec (
        .bcd (nibble),
        .seg (seg_dec)
    );

    assign digit_sel = 4'b0001 << digit_idx;
    assign dp        = (digit_idx == 2'd2);

`ifdef LEADING_ZERO_BLANK_EN
    assign seg = (digit_idx == 2'd3 && bcd_out[15:12] == 4'd0) ? SEG_BLANK : seg_dec;
`else
    assign seg = seg_dec;
`endif

endmodule
